// File: rtl/jpeg_coef_block_arbiter.sv
// Round-robin block arbiter: grants one DCT channel a whole coefficient block onto the shared quantizer path.
// Optional stall timeout abort is enabled with the JPEG_ARB_TIMEOUT_EN macro.
module jpeg_coef_block_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int COEF_W      = 12,
  parameter int BLOCK_LEN   = 64,
  parameter int QSEL_W      = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*COEF_W-1:0]    req_data,
  input  logic [NUM_REQ*QSEL_W-1:0]    req_qsel,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         dp_valid,
  output logic [COEF_W-1:0]            dp_data,
  output logic [QSEL_W-1:0]            dp_qsel,
  output logic [$clog2(NUM_REQ)-1:0]   dp_src,
  output logic                         dp_last,
  input  logic                         dp_ready,
  output logic                         busy,
  output logic                         err_abort
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BLOCK_LEN);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (BLOCK_LEN < 16 || BLOCK_LEN > 256 || (BLOCK_LEN & (BLOCK_LEN - 1)) != 0) begin : g_bad_block_len
    $error("BLOCK_LEN must be a power of two in 16..256");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [QSEL_W-1:0]  qsel_q, qsel_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [COEF_W-1:0]  data_arr [NUM_REQ];
  logic [QSEL_W-1:0]  qsel_arr [NUM_REQ];
  logic               pick_found;
  logic [SRC_W-1:0]   pick_idx;
  logic [SRC_W-1:0]   cand_idx;
  int                 cand_int;
  logic [SRC_W-1:0]   next_ptr;
  logic               xfer_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*COEF_W +: COEF_W];
      qsel_arr[i] = req_qsel[i*QSEL_W +: QSEL_W];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_int   = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_int = int'(rr_ptr_q) + i;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand_idx = SRC_W'(cand_int);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign next_ptr = (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    dp_valid  = 1'b0;
    dp_data   = '0;
    dp_last   = 1'b0;
    busy      = 1'b0;
    if (state_q == XFER) begin
      busy               = 1'b1;
      dp_valid           = req_valid[grant_q];
      dp_data            = data_arr[grant_q];
      req_ready[grant_q] = dp_ready;
      dp_last            = dp_valid & (count_q == CNT_W'(BLOCK_LEN - 1));
    end
    xfer_fire = dp_valid & dp_ready;
  end

  assign dp_src  = grant_q;
  assign dp_qsel = qsel_q;

`ifdef JPEG_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    qsel_d   = qsel_q;
    count_d  = count_q;
`ifdef JPEG_ARB_TIMEOUT_EN
    stall_d  = stall_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          qsel_d  = qsel_arr[pick_idx];
          count_d = '0;
          state_d = XFER;
`ifdef JPEG_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      XFER: begin
        if (xfer_fire) begin
`ifdef JPEG_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (dp_last) begin
            count_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
`ifdef JPEG_ARB_TIMEOUT_EN
        // Only a silent source counts as starvation; datapath backpressure does not.
        else if (!req_valid[grant_q]) begin
          if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            err_d    = 1'b1;
            stall_d  = '0;
            count_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      qsel_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      qsel_q   <= qsel_d;
      count_q  <= count_d;
    end
  end

`ifdef JPEG_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_abort = err_q;
`else
  assign err_abort = 1'b0;
`endif

endmodule
